// File: rtl/morse_pkg.sv
// Shared types and defaults for the push-button Morse front end.
// Latency: n/a (declarations only).
// Backpressure: n/a; the downstream stage samples a one-cycle strobe.
package morse_pkg;

  // Character-assembly FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    GAP     = 2'd2
  } state_e;

  // Symbol encoding inside the published pattern
  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

  // Default timing, in clock cycles
  localparam int DEF_DASH_THRESH = 2500;
  localparam int DEF_MIN_PRESS   = 16;
  localparam int DEF_CHAR_GAP    = 2500;
  localparam int DEF_CNT_W       = 16;

  // Pattern / mask width: at most eight symbols per character
  localparam int SYM_W = 8;

endpackage

// File: rtl/morse_btn_sync.sv
// Two-flop synchronizer bringing the raw button level into the clk domain.
// Latency: 2 cycles from input change to sync_o.
// Backpressure: none; free-running level path.
module morse_btn_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // Shift the asynchronous level through two flops to settle metastability
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/morse_input.sv
// Classifies button presses as dot/dash and publishes one character per gap.
// Latency: 2-cycle input sync, then the strobe fires CHAR_GAP+1 released cycles after a symbol.
// Backpressure: none; outputs hold until the next character, ready is a single-cycle pulse.
module morse_input
  import morse_pkg::*;
#(
  parameter int DASH_THRESH = DEF_DASH_THRESH,
  parameter int MIN_PRESS   = DEF_MIN_PRESS,
  parameter int CHAR_GAP    = DEF_CHAR_GAP,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  output logic [SYM_W-1:0] morse_array,
  output logic [SYM_W-1:0] morse_arrayy,
  output logic             new_input_ready
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DASH_C   = CNT_W'(DASH_THRESH);
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_PRESS);
  localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(CHAR_GAP);

  logic             btn_s;
  state_e           state_q;
  logic [CNT_W-1:0] press_cnt_q;
  logic [CNT_W-1:0] press_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q;
  logic [CNT_W-1:0] gap_cnt_d;
  logic [SYM_W-1:0] pat_q;
  logic [SYM_W-1:0] msk_q;
  logic             sym;
  logic             press_short;
  logic             char_full;

  morse_btn_sync u_sync (
    .clk_i   (clk),
    .rst_ni  (rst),
    .async_i (button),
    .sync_o  (btn_s)
  );

  // Counters stick at all-ones so an endless hold still reads as a long press
  assign press_cnt_d = (&press_cnt_q) ? press_cnt_q : press_cnt_q + CNT_ONE;
  assign gap_cnt_d   = (&gap_cnt_q)   ? gap_cnt_q   : gap_cnt_q + CNT_ONE;

  // Classification of the press that is ending this cycle
  assign sym         = (press_cnt_q >= DASH_C) ? DASH : DOT;
  assign press_short = (press_cnt_q < MIN_C);
  // Mask fills from bit 0, so bit 7 set means eight symbols are already held
  assign char_full   = msk_q[SYM_W-1];

  // Character-assembly FSM with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      press_cnt_q     <= '0;
      gap_cnt_q       <= '0;
      pat_q           <= '0;
      msk_q           <= '0;
      morse_array     <= '0;
      morse_arrayy    <= '0;
      new_input_ready <= 1'b0;
    end else begin
      new_input_ready <= 1'b0;
      case (state_q)
        IDLE: begin
          if (btn_s) begin
            state_q     <= PRESSED;
            press_cnt_q <= CNT_ONE;
          end
        end

        PRESSED: begin
          if (btn_s) begin
            press_cnt_q <= press_cnt_d;
          end else begin
            gap_cnt_q <= '0;
            if (press_short) begin
              // Glitch: drop it and resume whatever we were doing before
              state_q <= (msk_q != '0) ? GAP : IDLE;
            end else begin
              if (!char_full) begin
                pat_q <= {pat_q[SYM_W-2:0], sym};
                msk_q <= {msk_q[SYM_W-2:0], 1'b1};
              end
              state_q <= GAP;
            end
          end
        end

        GAP: begin
          if (btn_s) begin
            state_q     <= PRESSED;
            press_cnt_q <= CNT_ONE;
          end else if (gap_cnt_d == GAP_C) begin
            // Long enough release: hand the character downstream and start fresh
            morse_array     <= pat_q;
            morse_arrayy    <= msk_q;
            new_input_ready <= 1'b1;
            pat_q           <= '0;
            msk_q           <= '0;
            gap_cnt_q       <= '0;
            state_q         <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_d;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_input.sv
// Directed bench for morse_input: dot/dash thresholds, glitches, overflow, reset.
// Latency: checks the completion strobe lands shortly after CHAR_GAP released cycles.
// Backpressure: none; every published character is captured by a monitor.
module tb_morse_input;

  localparam int CHAR_GAP = 2500;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       button = 1'b0;
  logic [7:0] morse_array;
  logic [7:0] morse_arrayy;
  logic       new_input_ready;

  int tot = 0;
  int bad = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  logic [7:0] cap_arr = 8'h00;
  logic [7:0] cap_msk = 8'h00;

  morse_input dut (
    .clk             (clk),
    .rst             (rst),
    .button          (button),
    .morse_array     (morse_array),
    .morse_arrayy    (morse_arrayy),
    .new_input_ready (new_input_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe and the values published with it
  always @(negedge clk) begin
    if (new_input_ready === 1'b1) begin
      pulse_cnt <= pulse_cnt + 1;
      cap_arr   <= morse_array;
      cap_msk   <= morse_arrayy;
    end
  end

  task automatic press(input int n);
    button = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    button = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bounded wait for a new strobe; reports latency from the call in cycles
  task automatic wait_pulse(input int start_cnt, input int bound, output bit got, output int lat);
    int t0;
    t0  = cyc;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clk);
      #1;
      if (pulse_cnt != start_cnt) begin
        got = 1'b1;
        lat = cyc - t0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      button = ~button;
      idle(1);
    end
    button = 1'b0;
    tot++; if (morse_array !== 8'h00) begin bad++; $display("FAIL reset_array: got %h want 00", morse_array); end
    tot++; if (morse_arrayy !== 8'h00) begin bad++; $display("FAIL reset_mask: got %h want 00", morse_arrayy); end
    tot++; if (new_input_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", new_input_ready); end
    rst = 1'b1;
    idle(10000);
    tot++; if (pulse_cnt !== 0) begin bad++; $display("FAIL reset_idle_pulses: got %0d want 0", pulse_cnt); end
  endtask

  task automatic test_u();
    int s; bit got; int lat;
    s = pulse_cnt;
    press(1512); idle(1512);
    press(1512); idle(1512);
    press(3750);
    wait_pulse(s, CHAR_GAP + 100, got, lat);
    tot++; if (!got) begin bad++; $display("FAIL u_timeout: got no pulse want pulse"); end
    tot++; if (lat < CHAR_GAP || lat > CHAR_GAP + 6) begin bad++; $display("FAIL u_latency: got %0d want %0d..%0d", lat, CHAR_GAP, CHAR_GAP + 6); end
    tot++; if (cap_arr !== 8'h01) begin bad++; $display("FAIL u_array: got %h want 01", cap_arr); end
    tot++; if (cap_msk !== 8'h07) begin bad++; $display("FAIL u_mask: got %h want 07", cap_msk); end
    idle(200);
    tot++; if (pulse_cnt - s !== 1) begin bad++; $display("FAIL u_pulse_count: got %0d want 1", pulse_cnt - s); end
  endtask

  task automatic test_i();
    int s; bit got; int lat;
    s = pulse_cnt;
    press(1512); idle(1512);
    press(1512);
    // previous character still held while the new one is being built
    tot++; if (morse_array !== 8'h01) begin bad++; $display("FAIL i_hold_array: got %h want 01", morse_array); end
    tot++; if (morse_arrayy !== 8'h07) begin bad++; $display("FAIL i_hold_mask: got %h want 07", morse_arrayy); end
    wait_pulse(s, CHAR_GAP + 100, got, lat);
    tot++; if (!got) begin bad++; $display("FAIL i_timeout: got no pulse want pulse"); end
    tot++; if (cap_arr !== 8'h00) begin bad++; $display("FAIL i_array: got %h want 00", cap_arr); end
    tot++; if (cap_msk !== 8'h03) begin bad++; $display("FAIL i_mask: got %h want 03", cap_msk); end
    idle(20);
    tot++; if (morse_arrayy !== 8'h03) begin bad++; $display("FAIL i_mask_held: got %h want 03", morse_arrayy); end
  endtask

  task automatic test_thresholds();
    int s; bit got; int lat;
    s = pulse_cnt;
    press(2499);
    wait_pulse(s, CHAR_GAP + 100, got, lat);
    tot++; if (!got) begin bad++; $display("FAIL th2499_timeout: got no pulse want pulse"); end
    tot++; if (cap_arr !== 8'h00 || cap_msk !== 8'h01) begin bad++; $display("FAIL th2499: got %h/%h want 00/01", cap_arr, cap_msk); end
    idle(20);
    s = pulse_cnt;
    press(2500);
    wait_pulse(s, CHAR_GAP + 100, got, lat);
    tot++; if (!got) begin bad++; $display("FAIL th2500_timeout: got no pulse want pulse"); end
    tot++; if (cap_arr !== 8'h01 || cap_msk !== 8'h01) begin bad++; $display("FAIL th2500: got %h/%h want 01/01", cap_arr, cap_msk); end
    idle(20);
    s = pulse_cnt;
    press(10);
    idle(CHAR_GAP + 100);
    tot++; if (pulse_cnt !== s) begin bad++; $display("FAIL glitch_alone: got %0d pulses want 0", pulse_cnt - s); end
    s = pulse_cnt;
    press(1512); idle(500);
    press(10);   idle(500);
    press(1512);
    wait_pulse(s, CHAR_GAP + 100, got, lat);
    tot++; if (!got) begin bad++; $display("FAIL glitch_mid_timeout: got no pulse want pulse"); end
    tot++; if (cap_arr !== 8'h00 || cap_msk !== 8'h03) begin bad++; $display("FAIL glitch_mid: got %h/%h want 00/03", cap_arr, cap_msk); end
    idle(20);
  endtask

  task automatic test_overflow();
    int s; bit got; int lat;
    s = pulse_cnt;
    for (int i = 0; i < 9; i++) begin
      press(2500);
      if (i < 8) idle(50);
    end
    wait_pulse(s, CHAR_GAP + 100, got, lat);
    tot++; if (!got) begin bad++; $display("FAIL ovf_timeout: got no pulse want pulse"); end
    tot++; if (cap_arr !== 8'hFF) begin bad++; $display("FAIL ovf_array: got %h want ff", cap_arr); end
    tot++; if (cap_msk !== 8'hFF) begin bad++; $display("FAIL ovf_mask: got %h want ff", cap_msk); end
    idle(200);
    tot++; if (pulse_cnt - s !== 1) begin bad++; $display("FAIL ovf_pulse_count: got %0d want 1", pulse_cnt - s); end
  endtask

  task automatic test_mid_reset();
    int s; bit got; int lat;
    s = pulse_cnt;
    press(1512); idle(300);
    press(1512); idle(300);
    rst = 1'b0;
    idle(5);
    tot++; if (morse_array !== 8'h00 || morse_arrayy !== 8'h00) begin bad++; $display("FAIL midrst_outputs: got %h/%h want 00/00", morse_array, morse_arrayy); end
    rst = 1'b1;
    idle(CHAR_GAP + 100);
    tot++; if (pulse_cnt !== s) begin bad++; $display("FAIL midrst_no_pulse: got %0d pulses want 0", pulse_cnt - s); end
    s = pulse_cnt;
    press(1512);
    wait_pulse(s, CHAR_GAP + 100, got, lat);
    tot++; if (!got) begin bad++; $display("FAIL e_timeout: got no pulse want pulse"); end
    tot++; if (cap_arr !== 8'h00 || cap_msk !== 8'h01) begin bad++; $display("FAIL e_char: got %h/%h want 00/01", cap_arr, cap_msk); end
    idle(20);
  endtask

  initial begin
    test_reset();
    test_u();
    test_i();
    test_thresholds();
    test_overflow();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
